// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit framer: FSM state encoding, parity
// selection, and the decode that maps the reserved parity code to NONE.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    s_IDLE          = 3'd0,
    s_TX_START_BIT  = 3'd1,
    s_TX_DATA_BITS  = 3'd2,
    s_TX_PARITY_BIT = 3'd3,
    s_TX_STOP_BIT   = 3'd4,
    s_CLEANUP       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  function automatic parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PARITY_EVEN;
      2'd2:    return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Bit-period counter: counts 0..divisor-1 and pulses o_Bit_End on the last
// count, wrapping to 0 in the same cycle. Held at 0 while i_Clear is high.
module uart_tx_baud_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Clear,
  input  logic [CNT_W-1:0] i_Divisor,
  output logic             o_Bit_End
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_Bit_End = !i_Clear && (cnt_q == i_Divisor - CNT_W'(1));
    cnt_d     = cnt_q + CNT_W'(1);
    if (i_Clear || o_Bit_End) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or
// two stop bits. Outputs are registered from next-state so they align with it.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [CNT_W-1:0]     i_Clks_Per_Bit,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Active,
  output logic                 o_TX_Done
);

  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d, data_shifted;
  logic [CNT_W-1:0]     div_q, div_d;
  parity_t              par_q, par_d;
  logic                 two_stop_q, two_stop_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 bit_end, accept, clear;

  assign o_TX_Ready  = (state_q == s_IDLE) && !i_Reset;
  assign accept      = i_TX_DV && o_TX_Ready;
  assign clear       = (state_q == s_IDLE) || (state_q == s_CLEANUP);
  assign o_TX_Serial = serial_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;

  uart_tx_baud_counter #(.CNT_W(CNT_W)) u_baud (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (clear),
    .i_Divisor (div_q),
    .o_Bit_End (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    div_d      = div_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    unique case (state_q)
      s_IDLE: if (accept) begin
        state_d    = s_TX_START_BIT;
        idx_d      = '0;
        data_d     = i_TX_Byte;
        div_d      = (i_Clks_Per_Bit < CNT_W'(2)) ? CNT_W'(2) : i_Clks_Per_Bit;
        par_d      = decode_parity(i_Parity_Mode);
        two_stop_d = i_Two_Stop;
      end
      s_TX_START_BIT: if (bit_end) begin
        state_d = s_TX_DATA_BITS;
        idx_d   = '0;
      end
      s_TX_DATA_BITS: if (bit_end) begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = (par_q == PARITY_NONE) ? s_TX_STOP_BIT : s_TX_PARITY_BIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      s_TX_PARITY_BIT: if (bit_end) state_d = s_TX_STOP_BIT;
      // The index is reused to count stop bits once the data bits are done.
      s_TX_STOP_BIT: if (bit_end) begin
        if (idx_q == {3'b000, two_stop_q}) begin
          state_d = s_CLEANUP;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      s_CLEANUP: state_d = s_IDLE;
      default:   state_d = s_IDLE;
    endcase
  end

  assign data_shifted = data_q >> idx_d;

  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      s_TX_START_BIT:  serial_d = 1'b0;
      s_TX_DATA_BITS:  serial_d = data_shifted[0];
      s_TX_PARITY_BIT: serial_d = (^data_q) ^ (par_q == PARITY_ODD);
      default:         serial_d = 1'b1;
    endcase
    active_d = (state_d == s_TX_START_BIT) || (state_d == s_TX_DATA_BITS) ||
               (state_d == s_TX_PARITY_BIT) || (state_d == s_TX_STOP_BIT);
    done_d   = (state_d == s_CLEANUP);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= s_IDLE;
      idx_q    <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // NOTE: payload and configuration are always written on accept before they
  // are used, so they carry no reset.
  always_ff @(posedge i_Clock) begin
    data_q     <= data_d;
    div_q      <= div_d;
    par_q      <= par_d;
    two_stop_q <= two_stop_d;
  end

endmodule
